// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   UART transmitter with an internal baud divider, a DEPTH-entry TX FIFO with
//   valid/ready push, configurable data width and stop bits, and runtime
//   even/odd/no parity selected per frame.
//
//   Optional feature macro: UART_TX_BREAK_EN
//     Defined   -> adds input break_req and the BREAK / MARK states
//                  (line held low, then one bit time of mark before IDLE).
//     Undefined -> no break_req port; the line is only low during
//                  start, data and parity bits.
//
//   tx_pin, tx_busy and tx_done come straight from flops. Their next values
//   are derived from the next FSM state, so a word pushed into an empty FIFO
//   on edge N drives the start bit right after edge N+1.
module uart_tx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int CLK_DIV   = 55,
  parameter int DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic [DATA_BITS-1:0]     in_data,
  output logic                     in_ready,
  input  logic                     parity_enable,
  input  logic                     parity_odd,
`ifdef UART_TX_BREAK_EN
  input  logic                     break_req,
`endif
  output logic                     tx_pin,
  output logic                     tx_busy,
  output logic                     tx_done,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  // Bit counter covers both data bits (max 9) and stop bits (max 2).
  localparam int CW = 4;

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
`ifdef UART_TX_BREAK_EN
    ,
    ST_BREAK  = 3'd5,
    ST_MARK   = 3'd6
`endif
  } state_t;

  // Even parity (XOR reduction) of one data word.
  function automatic logic parity_f(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

  // ------------------------------------------------------------------
  // FIFO storage and pointers (extra wrap bit distinguishes full/empty)
  // ------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem_r [DEPTH];
  logic [AW:0]          wr_ptr_r;
  logic [AW:0]          rd_ptr_r;
  logic                 full_s;
  logic                 empty_s;
  logic                 push_s;
  logic                 pop_s;
  logic [DATA_BITS-1:0] head_s;

  // FSM and datapath state
  state_t               state_r;
  state_t               state_nx_s;
  logic [DW-1:0]        div_r;
  logic [DW-1:0]        div_nx_s;
  logic                 tick_s;
  logic [CW-1:0]        bit_cnt_r;
  logic [CW-1:0]        bit_cnt_nx_s;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] shift_nx_s;
  logic                 par_en_r;
  logic                 par_bit_r;
  logic                 done_nx_s;

  // Registered outputs
  logic                 tx_pin_r;
  logic                 tx_busy_r;
  logic                 tx_done_r;
  logic                 pin_nx_s;
  logic                 busy_nx_s;

  // FIFO status flags, push qualification and head-of-queue read.
  always_comb begin
    empty_s = (wr_ptr_r == rd_ptr_r);
    full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
              (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    push_s  = in_valid & ~full_s;
    head_s  = mem_r[rd_ptr_r[AW-1:0]];
  end

  assign in_ready   = ~full_s;
  assign fifo_level = wr_ptr_r - rd_ptr_r;

  // FIFO data array write; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= in_data;
    end
  end

  // FIFO pointer update; a simultaneous push and pop leaves the level unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
    end
  end

  // ------------------------------------------------------------------
  // Transmit FSM
  // ------------------------------------------------------------------
  assign tick_s = (div_r == DIV_LAST);

  // State, divider, shift register, latched parity settings and output flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      div_r     <= '0;
      bit_cnt_r <= '0;
      shift_r   <= '0;
      par_en_r  <= 1'b0;
      par_bit_r <= 1'b0;
      tx_pin_r  <= 1'b1;
      tx_busy_r <= 1'b0;
      tx_done_r <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      div_r     <= div_nx_s;
      bit_cnt_r <= bit_cnt_nx_s;
      shift_r   <= shift_nx_s;
      if (pop_s) begin
        // Parity mode is frozen per frame at the moment the word is popped.
        par_en_r  <= parity_enable;
        par_bit_r <= parity_f(head_s) ^ parity_odd;
      end
      tx_pin_r  <= pin_nx_s;
      tx_busy_r <= busy_nx_s;
      tx_done_r <= done_nx_s;
    end
  end

  // Next-state logic: bit sequencing, FIFO pops, bit counter and end-of-frame pulse.
  always_comb begin
    state_nx_s   = state_r;
    pop_s        = 1'b0;
    done_nx_s    = 1'b0;
    bit_cnt_nx_s = bit_cnt_r;
    case (state_r)
      ST_IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (break_req) begin
          state_nx_s = ST_BREAK;
        end else
`endif
        if (!empty_s) begin
          state_nx_s = ST_START;
          pop_s      = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s) begin
          state_nx_s   = ST_DATA;
          bit_cnt_nx_s = '0;
        end else begin
          state_nx_s = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s) begin
          if (bit_cnt_r == DATA_LAST) begin
            bit_cnt_nx_s = '0;
            state_nx_s   = par_en_r ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_nx_s = bit_cnt_r + CW'(1);
            state_nx_s   = ST_DATA;
          end
        end else begin
          state_nx_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (tick_s) begin
          state_nx_s   = ST_STOP;
          bit_cnt_nx_s = '0;
        end else begin
          state_nx_s = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (tick_s) begin
          if (bit_cnt_r == STOP_LAST) begin
            done_nx_s    = 1'b1;
            bit_cnt_nx_s = '0;
            // Back-to-back: next start bit begins on the same edge.
            if (!empty_s) begin
              state_nx_s = ST_START;
              pop_s      = 1'b1;
            end else begin
              state_nx_s = ST_IDLE;
            end
          end else begin
            bit_cnt_nx_s = bit_cnt_r + CW'(1);
            state_nx_s   = ST_STOP;
          end
        end else begin
          state_nx_s = ST_STOP;
        end
      end
`ifdef UART_TX_BREAK_EN
      ST_BREAK: begin
        if (!break_req) begin
          state_nx_s = ST_MARK;
        end else begin
          state_nx_s = ST_BREAK;
        end
      end
      ST_MARK: begin
        // End of the mark bit makes the same decision IDLE would, so the
        // mark lasts exactly one bit time before any queued frame starts.
        if (tick_s) begin
          if (break_req) begin
            state_nx_s = ST_BREAK;
          end else if (!empty_s) begin
            state_nx_s = ST_START;
            pop_s      = 1'b1;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end else begin
          state_nx_s = ST_MARK;
        end
      end
`endif
      default: begin
        state_nx_s   = ST_IDLE;
        bit_cnt_nx_s = '0;
      end
    endcase
  end

  // Baud divider: held at zero while idle (or in break), wraps every CLK_DIV clocks otherwise.
  always_comb begin
    div_nx_s = div_r;
    if (state_r == ST_IDLE) begin
      div_nx_s = '0;
`ifdef UART_TX_BREAK_EN
    end else if (state_r == ST_BREAK) begin
      div_nx_s = '0;
`endif
    end else if (tick_s) begin
      div_nx_s = '0;
    end else begin
      div_nx_s = div_r + DW'(1);
    end
  end

  // Output logic: shift register next value and next line/busy levels from the next state.
  always_comb begin
    shift_nx_s = shift_r;
    pin_nx_s   = 1'b1;
    if (pop_s) begin
      shift_nx_s = head_s;
    end else if ((state_r == ST_DATA) && tick_s) begin
      shift_nx_s = {1'b0, shift_r[DATA_BITS-1:1]};
    end else begin
      shift_nx_s = shift_r;
    end
    case (state_nx_s)
      ST_IDLE:   pin_nx_s = 1'b1;
      ST_START:  pin_nx_s = 1'b0;
      ST_DATA:   pin_nx_s = shift_nx_s[0];
      ST_PARITY: pin_nx_s = par_bit_r;
      ST_STOP:   pin_nx_s = 1'b1;
`ifdef UART_TX_BREAK_EN
      ST_BREAK:  pin_nx_s = 1'b0;
      ST_MARK:   pin_nx_s = 1'b1;
`endif
      default:   pin_nx_s = 1'b1;
    endcase
    busy_nx_s = (state_nx_s != ST_IDLE);
  end

  assign tx_pin  = tx_pin_r;
  assign tx_busy = tx_busy_r;
  assign tx_done = tx_done_r;

endmodule
